// File: rtl/dual_port_bram_mm.sv
// True dual-port RAM on one clock with byte-lane writes, selectable write mode and read latency,
// and a clear engine that sweeps InitValue into every word after reset or on request.
module dual_port_bram_mm #(
   parameter int unsigned      Depth       = 512,
   parameter int unsigned      Width       = 36,
   parameter int unsigned      ByteWidth   = 9,
   parameter int unsigned      ReadLatency = 1,
   parameter int unsigned      WriteMode   = 0,
   parameter logic [Width-1:0] InitValue   = '0,
   localparam int unsigned     NB          = Width / ByteWidth,
   localparam int unsigned     AW          = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   output logic             ready,
   input  logic             en_0,
   input  logic             en_1,
   input  logic [NB-1:0]    wen_0,
   input  logic [NB-1:0]    wen_1,
   input  logic [AW-1:0]    addr_0,
   input  logic [AW-1:0]    addr_1,
   input  logic [Width-1:0] din_0,
   input  logic [Width-1:0] din_1,
   output logic [Width-1:0] dout_0,
   output logic [Width-1:0] dout_1,
   output logic             dout_valid_0,
   output logic             dout_valid_1,
   output logic             collision
);

   typedef enum logic {StClear, StReady} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [Width-1:0] mem [Depth];

   logic             acc_0, acc_1, wr_0, wr_1, same_addr;
   logic [NB-1:0]    wen_1_eff;
   logic [Width-1:0] old_0, old_1, new_0, new_1, rd_0, rd_1;
   logic             upd_0, upd_1, coll_d;

   logic [Width-1:0] d1_0_q, d1_1_q, d2_0_q, d2_1_q;
   logic             v1_0_q, v1_1_q, v2_0_q, v2_1_q, c1_q, c2_q;

   function automatic logic [Width-1:0] merge(input logic [Width-1:0] old,
                                              input logic [Width-1:0] din,
                                              input logic [NB-1:0]    we);
      merge = old;
      for (int i = 0; i < NB; i++) begin
         if (we[i]) merge[i*ByteWidth +: ByteWidth] = din[i*ByteWidth +: ByteWidth];
      end
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StClear: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(Depth - 1)) state_d = StReady;
         end
         StReady: begin
            if (clr) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
      endcase
   end

   assign ready = (state_q == StReady);

   always_comb begin
      acc_0     = ready & en_0;
      acc_1     = ready & en_1;
      wr_0      = acc_0 & (|wen_0);
      wr_1      = acc_1 & (|wen_1);
      same_addr = (addr_0 == addr_1);
      old_0     = mem[addr_0];
      old_1     = mem[addr_1];
      // Port 0 owns every lane it enables when both ports write the same word.
      wen_1_eff = (wr_0 && same_addr) ? (wen_1 & ~wen_0) : wen_1;
      new_0     = merge(merge(old_0, din_0, wen_0), din_1, (wr_1 && same_addr) ? wen_1_eff : '0);
      new_1     = merge(merge(old_1, din_1, wen_1_eff), din_0, (wr_0 && same_addr) ? wen_0 : '0);
      upd_0     = acc_0 && (!wr_0 || (WriteMode != 2));
      upd_1     = acc_1 && (!wr_1 || (WriteMode != 2));
      rd_0      = (wr_0 && (WriteMode == 1)) ? new_0 : old_0;
      rd_1      = (wr_1 && (WriteMode == 1)) ? new_1 : old_1;
      coll_d    = wr_0 & wr_1 & same_addr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage carries no reset; the sweep is what initialises it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (!ready) begin
            mem[cnt_q] <= InitValue;
         end else begin
            if (wr_0) mem[addr_0] <= new_0;
            if (wr_1) mem[addr_1] <= new_1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d1_0_q <= '0;
         d1_1_q <= '0;
         d2_0_q <= '0;
         d2_1_q <= '0;
         v1_0_q <= 1'b0;
         v1_1_q <= 1'b0;
         v2_0_q <= 1'b0;
         v2_1_q <= 1'b0;
         c1_q   <= 1'b0;
         c2_q   <= 1'b0;
      end else begin
         v1_0_q <= upd_0;
         v1_1_q <= upd_1;
         c1_q   <= coll_d;
         if (upd_0) d1_0_q <= rd_0;
         if (upd_1) d1_1_q <= rd_1;
         v2_0_q <= v1_0_q;
         v2_1_q <= v1_1_q;
         c2_q   <= c1_q;
         if (v1_0_q) d2_0_q <= d1_0_q;
         if (v1_1_q) d2_1_q <= d1_1_q;
      end
   end

   assign dout_0       = (ReadLatency == 2) ? d2_0_q : d1_0_q;
   assign dout_1       = (ReadLatency == 2) ? d2_1_q : d1_1_q;
   assign dout_valid_0 = (ReadLatency == 2) ? v2_0_q : v1_0_q;
   assign dout_valid_1 = (ReadLatency == 2) ? v2_1_q : v1_1_q;
   assign collision    = (ReadLatency == 2) ? c2_q : c1_q;

endmodule

// File: tb/tb_dual_port_bram_mm.sv
// Bench for dual_port_bram_mm: four instances (three write modes at latency 1, read-first at
// latency 2) share one stimulus stream and are compared every cycle against a word-level model.
module tb_dual_port_bram_mm;
   localparam int unsigned D  = 16;
   localparam int unsigned W  = 36;
   localparam int unsigned BW = 9;
   localparam int unsigned NB = 4;
   localparam int unsigned AW = 4;
   localparam logic [W-1:0] INIT = 36'h5A5;

   logic          clk = 1'b0;
   logic          rst_n, clr, en_0, en_1;
   logic [NB-1:0] wen_0, wen_1;
   logic [AW-1:0] addr_0, addr_1;
   logic [W-1:0]  din_0, din_1;
   logic [W-1:0]  dout_0_w [4];
   logic [W-1:0]  dout_1_w [4];
   logic          rdy_w [4];
   logic          val_0_w [4];
   logic          val_1_w [4];
   logic          coll_w [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      dual_port_bram_mm #(
         .Depth      (D),
         .Width      (W),
         .ByteWidth  (BW),
         .ReadLatency((k == 3) ? 2 : 1),
         .WriteMode  ((k == 3) ? 0 : k),
         .InitValue  (INIT)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .clr         (clr),
         .ready       (rdy_w[k]),
         .en_0        (en_0),
         .en_1        (en_1),
         .wen_0       (wen_0),
         .wen_1       (wen_1),
         .addr_0      (addr_0),
         .addr_1      (addr_1),
         .din_0       (din_0),
         .din_1       (din_1),
         .dout_0      (dout_0_w[k]),
         .dout_1      (dout_1_w[k]),
         .dout_valid_0(val_0_w[k]),
         .dout_valid_1(val_1_w[k]),
         .collision   (coll_w[k])
      );
   end

   // Model: remaining sweep cycles, word array, latency-1 results per write mode, and the
   // latency-2 view of the read-first results.
   int unsigned  m_left = D;
   logic [W-1:0] m_mem [D];
   logic [W-1:0] x_dout [3][2];
   logic         x_val [3][2];
   logic         x_coll = 1'b0;
   logic [W-1:0] l2_dout [2];
   logic         l2_val [2];
   logic         l2_coll = 1'b0;

   task automatic model_edge();
      logic          acc [2];
      logic          wr [2];
      logic [NB-1:0] we [2];
      logic [AW-1:0] a [2];
      logic [W-1:0]  d [2];
      logic [W-1:0]  pre [2];
      if (!rst_n) begin
         m_left  = D;
         x_coll  = 1'b0;
         l2_coll = 1'b0;
         for (int p = 0; p < 2; p++) begin
            l2_val[p]  = 1'b0;
            l2_dout[p] = '0;
            for (int m = 0; m < 3; m++) begin
               x_val[m][p]  = 1'b0;
               x_dout[m][p] = '0;
            end
         end
         return;
      end
      for (int p = 0; p < 2; p++) begin
         l2_val[p] = x_val[0][p];
         if (x_val[0][p]) l2_dout[p] = x_dout[0][p];
      end
      l2_coll = x_coll;
      x_coll  = 1'b0;
      for (int m = 0; m < 3; m++) for (int p = 0; p < 2; p++) x_val[m][p] = 1'b0;
      if (m_left != 0) begin
         m_mem[D - m_left] = INIT;
         m_left--;
         return;
      end
      acc = '{en_0, en_1};
      we  = '{wen_0, wen_1};
      a   = '{addr_0, addr_1};
      d   = '{din_0, din_1};
      for (int p = 0; p < 2; p++) begin
         wr[p]  = acc[p] && (we[p] != '0);
         pre[p] = m_mem[a[p]];
      end
      // Port 1 lanes first so that port 0 overwrites any lane both ports enable.
      for (int p = 1; p >= 0; p--) begin
         if (wr[p]) begin
            for (int i = 0; i < NB; i++)
               if (we[p][i]) m_mem[a[p]][i*BW +: BW] = d[p][i*BW +: BW];
         end
      end
      for (int m = 0; m < 3; m++) begin
         for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
               if (!wr[p] || m == 0) begin
                  x_dout[m][p] = pre[p];
                  x_val[m][p]  = 1'b1;
               end else if (m == 1) begin
                  x_dout[m][p] = m_mem[a[p]];
                  x_val[m][p]  = 1'b1;
               end
            end
         end
      end
      x_coll = wr[0] && wr[1] && (a[0] == a[1]);
      if (clr) m_left = D;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         logic [W-1:0] e_d0, e_d1;
         logic         e_v0, e_v1, e_c;
         if (k < 3) begin
            e_d0 = x_dout[k][0];
            e_d1 = x_dout[k][1];
            e_v0 = x_val[k][0];
            e_v1 = x_val[k][1];
            e_c  = x_coll;
         end else begin
            e_d0 = l2_dout[0];
            e_d1 = l2_dout[1];
            e_v0 = l2_val[0];
            e_v1 = l2_val[1];
            e_c  = l2_coll;
         end
         chk($sformatf("ready[%0d]", k), 64'(rdy_w[k]), 64'(m_left == 0));
         chk($sformatf("dout_0[%0d]", k), 64'(dout_0_w[k]), 64'(e_d0));
         chk($sformatf("dout_1[%0d]", k), 64'(dout_1_w[k]), 64'(e_d1));
         chk($sformatf("dout_valid_0[%0d]", k), 64'(val_0_w[k]), 64'(e_v0));
         chk($sformatf("dout_valid_1[%0d]", k), 64'(val_1_w[k]), 64'(e_v1));
         chk($sformatf("collision[%0d]", k), 64'(coll_w[k]), 64'(e_c));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic e0, input logic [NB-1:0] w0, input logic [AW-1:0] a0,
                        input logic [W-1:0] d0, input logic e1, input logic [NB-1:0] w1,
                        input logic [AW-1:0] a1, input logic [W-1:0] d1);
      en_0   = e0;
      wen_0  = w0;
      addr_0 = a0;
      din_0  = d0;
      en_1   = e1;
      wen_1  = w1;
      addr_1 = a1;
      din_1  = d1;
   endtask

   task automatic rand_drive(input bit narrow);
      logic [AW-1:0] a0, a1;
      a0 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      a1 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      drive(1'($urandom), ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom), a0,
            W'({$urandom, $urandom}), 1'($urandom),
            ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom), a1, W'({$urandom, $urandom}));
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      logic [W-1:0] lane_mask, va, vb;
      lane_mask = {9'h000, 9'h1FF, 9'h000, 9'h1FF};
      va = 36'hA_AAAA_AAAA;
      vb = 36'h5_5555_5555;
      rst_n = 1'b0;
      clr   = 1'b0;
      idle();
      repeat (3) step();

      // Release; accesses presented during the sweep must be ignored.
      rst_n = 1'b1;
      for (int i = 0; i < D; i++) begin
         rand_drive(1'b0);
         step();
      end
      chk("ready_after_sweep", 64'(rdy_w[0]), 64'(1));
      for (int i = 0; i < D; i++) begin
         drive(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(D - 1 - i), '0);
         step();
         chk("init_word", 64'(dout_0_w[0]), 64'(INIT));
      end

      // Byte lanes over a zeroed word.
      drive(1'b1, '1, 4'd0, '0, 1'b0, '0, '0, '0);
      step();
      drive(1'b1, 4'b0101, 4'd0, 36'h1_2345_6789, 1'b0, '0, '0, '0);
      step();
      drive(1'b1, '0, 4'd0, '0, 1'b0, '0, '0, '0);
      step();
      chk("byte_lanes", 64'(dout_0_w[0]), 64'(36'h1_2345_6789 & lane_mask));

      // Write modes: address 3 holds A, port 1 writes B.
      drive(1'b1, '1, 4'd3, va, 1'b0, '0, '0, '0);
      step();
      drive(1'b0, '0, '0, '0, 1'b1, '1, 4'd3, vb);
      step();
      chk("wm_read_first", 64'(dout_1_w[0]), 64'(va));
      chk("wm_write_first", 64'(dout_1_w[1]), 64'(vb));
      drive(1'b0, '0, '0, '0, 1'b1, '0, 4'd3, '0);
      step();
      for (int k = 0; k < 3; k++) chk("wm_readback", 64'(dout_1_w[k]), 64'(vb));

      // Same-address collisions, full lanes then port 0 on lane 0 only.
      drive(1'b1, '1, 4'd7, 36'h1_1111_1111, 1'b1, '1, 4'd7, 36'h2_2222_2222);
      step();
      drive(1'b1, '0, 4'd7, '0, 1'b0, '0, '0, '0);
      step();
      chk("coll_full", 64'(dout_0_w[0]), 64'(36'h1_1111_1111));
      drive(1'b1, 4'b0001, 4'd7, 36'h3_3333_3333, 1'b1, '1, 4'd7, 36'h4_4444_4444);
      step();
      drive(1'b1, '0, 4'd7, '0, 1'b0, '0, '0, '0);
      step();

      // Port 0 writes while port 1 reads the same word.
      drive(1'b1, '1, 4'd2, 36'h9_8765_4321, 1'b1, '0, 4'd2, '0);
      step();
      drive(1'b0, '0, '0, '0, 1'b1, '0, 4'd2, '0);
      step();

      for (int i = 0; i < 300; i++) begin
         rand_drive(i[0]);
         clr = ($urandom_range(0, 63) == 0);
         step();
      end
      clr = 1'b0;
      repeat (D) begin
         rand_drive(1'b0);
         step();
      end

      // clr mid-stream with traffic continuing through the sweep.
      repeat (4) begin
         rand_drive(1'b1);
         step();
      end
      clr = 1'b1;
      rand_drive(1'b1);
      step();
      clr = 1'b0;
      chk("clr_ready_low", 64'(rdy_w[3]), 64'(0));
      repeat (D + 4) begin
         rand_drive(1'b1);
         step();
      end

      // Reset pulse nine cycles into a sweep.
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (9) begin
         rand_drive(1'b0);
         step();
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (D + 4) begin
         rand_drive(1'b1);
         step();
      end

      // clr held high: back-to-back sweeps with one ready cycle between them.
      clr = 1'b1;
      repeat (3 * D + 5) begin
         rand_drive(1'b1);
         step();
      end
      clr = 1'b0;
      idle();
      repeat (D + 2) step();
      for (int i = 0; i < D; i++) begin
         drive(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(i), '0);
         step();
      end
      idle();
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
